// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared states and constants for the boot-time instruction memory loader
package im_loader_pkg;
    localparam int ADDR_W = 12;
    localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 12'hc00;
    localparam int DEPTH_DEF = 1024;
    typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR} state_t;
endpackage

// File: rtl/im_word_assembler.sv
// im_word_assembler: packs accepted bytes into big-endian words and keeps their running XOR
module im_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic [7:0]  o_xor
);
    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic [7:0]  r_xor;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_xor   <= '0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_xor   <= '0;
        end else if (i_en) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
            r_xor   <= r_xor ^ i_byte;
        end
    end
    // The fourth byte completes the word in the same cycle it is accepted
    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_en && (r_cnt == 2'd3);
    assign o_xor        = r_xor;
endmodule

// File: rtl/im_loader.sv
// im_loader: writes a counted, checksummed byte stream into the IM and holds the CPU until it is accepted
module im_loader
    import im_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int                DEPTH     = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    state_t            r_state, w_next;
    logic [7:0]        r_cnt_hi;
    logic [15:0]       r_n, r_words;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       w_count;
    logic [31:0]       w_word;
    logic [7:0]        w_xor;
    logic              w_acc, w_restart, w_word_valid;

    assign rx_ready  = (r_state != DONE) && (r_state != ERR);
    assign w_acc     = rx_valid && rx_ready;
    assign w_count   = {r_cnt_hi, rx_data};
    assign w_restart = start && !rx_ready;

    im_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (w_restart),
        .i_en         (w_acc && (r_state == DATA)),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_xor        (w_xor)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            CNT_HI: if (w_acc) w_next = CNT_LO;
            CNT_LO: if (w_acc) w_next = (32'(w_count) > DEPTH) ? ERR : (w_count == 16'd0) ? CSUM : DATA;
            DATA:   if (w_word_valid && (r_words + 16'd1 == r_n)) w_next = CSUM;
            CSUM:   if (w_acc) w_next = (rx_data == w_xor) ? DONE : ERR;
            default: if (start) w_next = CNT_HI;
        endcase
    end

    // Status outputs decode the next state so they land with the state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= CNT_HI;
            r_cnt_hi <= '0;
            r_n      <= '0;
            r_words  <= '0;
            r_addr   <= BASE_ADDR;
            im_we    <= 1'b0;
            im_addr  <= BASE_ADDR;
            im_wdata <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_state  <= w_next;
            im_we    <= w_word_valid;
            done     <= (w_next == DONE);
            err      <= (w_next == ERR);
            cpu_hold <= (w_next != DONE);
            if (w_acc && (r_state == CNT_HI)) r_cnt_hi <= rx_data;
            if (w_acc && (r_state == CNT_LO)) r_n <= w_count;
            if (w_restart) begin
                r_words <= '0;
                r_addr  <= BASE_ADDR;
            end else if (w_word_valid) begin
                r_words  <= r_words + 16'd1;
                r_addr   <= r_addr + ADDR_W'(1);
                im_addr  <= r_addr;
                im_wdata <= w_word;
            end
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized image loads checked against a stream-level reference model
`timescale 1ns/1ps
module tb_im_loader;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, im_we, cpu_hold, done, err;
    logic [11:0] im_addr;
    logic [31:0] im_wdata;
    int          n_chk = 0, n_pass = 0;
    logic [7:0]  stim[$];
    logic [43:0] got[$], exp_w[$];
    logic        exp_done, exp_err;

    im_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (im_we) got.push_back({im_addr, im_wdata});

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model();
        int n;
        logic [7:0] x;
        exp_w.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        x = 8'h00;
        n = int'({stim[0], stim[1]});
        if (n > 1024) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_w.push_back({12'(12'hc00 + i), stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]});
            x ^= stim[2+4*i] ^ stim[3+4*i] ^ stim[4+4*i] ^ stim[5+4*i];
        end
        if (stim[2+4*n] == x) exp_done = 1'b1;
        else exp_err = 1'b1;
    endtask

    task automatic make(input int n, input bit bad);
        logic [7:0] x, b;
        stim.delete();
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stim.push_back(b);
            x ^= b;
        end
        stim.push_back(bad ? x ^ 8'($urandom_range(1, 255)) : x);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit ok;
        if (gap > 0) begin
            #1 rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
        end
        #1 rx_valid = 1'b1;
        rx_data = b;
        for (int i = 0; i < 50; i++) begin
            ok = rx_ready;
            @(posedge clk);
            if (ok) return;
            #1;
        end
        chk("rx_timeout", 44'd0, 44'd1);
    endtask

    task automatic run_load(input int gap_max, input string tag);
        model();
        got.delete();
        foreach (stim[i]) send(stim[i], int'($urandom_range(gap_max)));
        #1 rx_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, 44'(done), 44'(exp_done));
        chk({tag, "_err"}, 44'(err), 44'(exp_err));
        chk({tag, "_hold"}, 44'(cpu_hold), 44'(!exp_done));
        chk({tag, "_ready"}, 44'(rx_ready), 44'd0);
        chk({tag, "_nwr"}, 44'(got.size()), 44'(exp_w.size()));
        foreach (exp_w[i]) chk({tag, "_wr"}, (i < got.size()) ? got[i] : 44'hx, exp_w[i]);
    endtask

    task automatic restart(input logic with_valid);
        #1 start = 1'b1;
        rx_valid = with_valid;
        rx_data = 8'h00;
        @(posedge clk);
        #1 start = 1'b0;
        rx_valid = 1'b0;
        chk("restart_ready", 44'(rx_ready), 44'd1);
        chk("restart_done", 44'(done), 44'd0);
        chk("restart_err", 44'(err), 44'd0);
        chk("restart_hold", 44'(cpu_hold), 44'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 44'(rx_ready), 44'd1);
        chk({tag, "_we"}, 44'(im_we), 44'd0);
        chk({tag, "_addr"}, 44'(im_addr), 44'hc00);
        chk({tag, "_wdata"}, 44'(im_wdata), 44'd0);
        chk({tag, "_hold"}, 44'(cpu_hold), 44'd1);
        chk({tag, "_done"}, 44'(done), 44'd0);
        chk({tag, "_err"}, 44'(err), 44'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b1;
        stim = '{8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3d};
        run_load(0, "n2");
        restart(1'b0);
        stim = '{8'h00, 8'h01, 8'hde, 8'had, 8'hbe, 8'hef, 8'h00};
        run_load(1, "badsum");
        restart(1'b0);
        stim = '{8'h04, 8'h01};
        run_load(0, "ovf");
        restart(1'b0);
        make(1024, 1'b0);
        run_load(2, "full");
        restart(1'b0);
        stim = '{8'h00, 8'h00, 8'h00};
        run_load(0, "empty");
        restart(1'b1);
        make(1, 1'b0);
        run_load(0, "after_start");
        restart(1'b0);
        repeat (6) begin
            make(int'($urandom_range(1, 8)), $urandom_range(0, 2) == 0);
            run_load(1, "rand");
            restart(1'b0);
        end
        make(2, 1'b0);
        got.delete();
        for (int i = 0; i < 8; i++) send(stim[i], 0);
        #2 reset = 1'b0;
        rx_valid = 1'b0;
        #1 chk_reset_vals("midrst");
        chk("midrst_nwr", 44'(got.size()), 44'd1);
        @(negedge clk) reset = 1'b1;
        make(1, 1'b0);
        run_load(0, "post_rst");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
